// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a valid/ready handshake, a 2-entry skid buffer,
// flush and a fixed bubble value. `define PIPE_STALL_CNT_EN adds the stall_cnt_o counter.
module pipe_stage_skid #(
    parameter int                   DATA_W     = 32,
    parameter logic [DATA_W-1:0]    BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                   CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // Handshake: a transfer happens on a posedge where valid and ready are both 1.
    // Upstream holds in_data_i while in_valid_i=1 and in_ready_o=0.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic              accept;
    logic              pop;

    assign accept      = in_valid_i & in_ready_q;
    assign pop         = out_valid_o & out_ready_i;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign in_ready_o  = in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // A same-cycle accept is killed; a same-cycle pop already completed downstream.
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_data_i;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Ready is registered from the next state so no combinational path crosses stages.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            main_q     <= BUBBLE_VAL;
            skid_q     <= BUBBLE_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Only reset clears the counter; flush leaves it alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed test-plan sequences plus random traffic,
// all compared against a queue-based reference model.
module tb_pipe_stage_skid;
    localparam int          DATA_W  = 32;
    localparam logic [31:0] BUBBLE  = 32'h0000_0013;
    localparam int          CNT_W   = 3;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt_o;
`endif

    pipe_stage_skid #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // clock
    always #5 clk_i = ~clk_i;

    // reference model: held entries in FIFO order, plus stall count
    logic [DATA_W-1:0] exp_q[$];
    int                cnt_m;
    int                total;
    int                bad;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_data;
        exp_data = (exp_q.size() > 0) ? exp_q[0] : BUBBLE;
        check_eq("out_valid", {31'd0, out_valid_o}, {31'd0, exp_q.size() > 0});
        check_eq("out_data", out_data_o, exp_data);
        check_eq("in_ready", {31'd0, in_ready_o}, {31'd0, exp_q.size() < 2});
`ifdef PIPE_STALL_CNT_EN
        check_eq("stall_cnt", {29'd0, stall_cnt_o}, cnt_m);
`endif
    endtask

    // Drive one cycle of inputs (called just after a negedge), advance the model,
    // then check outputs at the next negedge.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [DATA_W-1:0] d, input logic ordy);
        int sz;
        bit acc, pp;
        rst_ni      = ~rst;
        flush_i     = fl;
        in_valid_i  = iv;
        in_data_i   = d;
        out_ready_i = ordy;
        sz  = exp_q.size();
        acc = iv && (sz < 2);
        pp  = (sz > 0) && ordy;
        if (rst) begin
            exp_q.delete();
            cnt_m = 0;
        end else begin
            if (sz > 0 && !ordy && cnt_m < CNT_MAX) cnt_m++;
            if (pp) void'(exp_q.pop_front());
            if (fl) exp_q.delete();
            else if (acc) exp_q.push_back(d);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs();
    endtask

    initial begin
        logic [DATA_W-1:0] hold_d;
        logic              hold_v;
        total = 0;
        bad   = 0;
        cnt_m = 0;
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
        @(negedge clk_i);

        // reset with active inputs, then quiet cycles
        step(1, 0, 1, 32'hAAAA_AAAA, 0);
        step(1, 0, 1, 32'hAAAA_AAAA, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);

        // streaming
        step(0, 0, 1, 32'h1, 1);
        step(0, 0, 1, 32'h2, 1);
        step(0, 0, 1, 32'h3, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);

        // backpressure: 0x12 waits upstream until space frees
        step(0, 0, 1, 32'h10, 0);
        step(0, 0, 1, 32'h11, 0);
        step(0, 0, 1, 32'h12, 0);
        step(0, 0, 1, 32'h12, 0);
        step(0, 0, 1, 32'h12, 1);
        step(0, 0, 1, 32'h12, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);

        // flush while FULL with a colliding accept attempt
        step(0, 0, 1, 32'h30, 0);
        step(0, 0, 1, 32'h31, 0);
        step(0, 1, 1, 32'h99, 0);
        step(0, 0, 1, 32'h20, 0);
        step(0, 0, 0, 32'h0, 1);

        // pop to empty shows the bubble value
        step(0, 0, 1, 32'h40, 0);
        step(0, 0, 0, 32'h0, 1);

        // stall counter saturation; flush keeps the count
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h50, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);

        // random traffic; data is held while an offer is pending
        hold_v = 1'b0;
        hold_d = '0;
        for (int i = 0; i < 600; i++) begin
            logic              iv;
            logic [DATA_W-1:0] d;
            logic              pending;
            pending = hold_v && !in_ready_o;
            iv = pending ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            d  = pending ? hold_d : $urandom;
            hold_v = iv;
            hold_d = d;
            step($urandom_range(0, 79) == 0, $urandom_range(0, 19) == 0, iv, d,
                 $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
